// File: rtl/prog_sequencer.sv
// Run controller for the 9-bit processor: owns the PC, the Start/Done handshake,
// jump qualification, memory-stall hold, halt/range-fault detection and benchmark counters.
module prog_sequencer #(
  parameter int         PC_W       = 10,
  parameter int         PROG_DEPTH = 1024,
  parameter logic [8:0] HALT_OP    = 9'b111111111
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [8:0]      Instruction,
  input  logic            Jump,
  input  logic            BranchEn,
  input  logic [PC_W-1:0] Target,
  input  logic            MemStall,
  output logic [PC_W-1:0] ProgCtr,
  output logic            InstrValid,
  output logic            Done,
  output logic            Fault,
  output logic [15:0]     CycleCount,
  output logic [15:0]     InstrCount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // One extra bit so a depth of 2**PC_W is representable in the range check.
  localparam logic [PC_W:0]   DEPTH_W = (PC_W+1)'(PROG_DEPTH);
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_DEPTH - 1);

  state_t          state, state_nx;
  logic [PC_W-1:0] pc_nx;
  logic [15:0]     cyc_nx, ins_nx;
  logic            start_p1;
  logic            is_halt, taken, tgt_bad, at_end;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    is_halt = (Instruction == HALT_OP);
    taken   = Jump && BranchEn;
    tgt_bad = ({1'b0, Target} >= DEPTH_W);
    at_end  = (ProgCtr == LAST_PC);
  end

  assign InstrValid = (state == S_RUN) && !MemStall && !is_halt;

  always_comb begin
    state_nx = state;
    pc_nx    = ProgCtr;
    cyc_nx   = CycleCount;
    ins_nx   = InstrCount;
    if (Start) begin
      // Start is a restart from any state: everything returns to a clean IDLE.
      state_nx = S_IDLE;
      pc_nx    = '0;
      cyc_nx   = '0;
      ins_nx   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_p1) state_nx = S_RUN;
        end
        S_RUN: begin
          cyc_nx = sat_inc(CycleCount);
          if (is_halt) begin
            state_nx = S_HALT;
          end else if (!MemStall) begin
            // A redirect that leaves the program space still commits, but the PC holds.
            ins_nx = sat_inc(InstrCount);
            if (taken) begin
              if (tgt_bad) state_nx = S_FAULT;
              else         pc_nx    = Target;
            end else begin
              if (at_end) state_nx = S_FAULT;
              else        pc_nx    = ProgCtr + 1'b1;
            end
          end
        end
        S_HALT:  state_nx = S_HALT;
        S_FAULT: state_nx = S_FAULT;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      start_p1   <= 1'b0;
      ProgCtr    <= '0;
      CycleCount <= '0;
      InstrCount <= '0;
      Done       <= 1'b0;
      Fault      <= 1'b0;
    end else begin
      state      <= state_nx;
      start_p1   <= Start;
      ProgCtr    <= pc_nx;
      CycleCount <= cyc_nx;
      InstrCount <= ins_nx;
      Done       <= (state_nx == S_HALT) || (state_nx == S_FAULT);
      Fault      <= (state_nx == S_FAULT);
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a full-depth instance and a 16-word instance share stimulus
// and are checked against a behavioural run model plus directed expectations.
module tb_prog_sequencer;

  localparam logic [8:0] HALT = 9'h1FF;
  localparam logic [8:0] NOP  = 9'h000;

  logic        clk, rst, start, jump, br, stall;
  logic [9:0]  target;
  logic [8:0]  rom [0:1023];
  logic [8:0]  instr_a, instr_b;
  logic [9:0]  pc_a;
  logic [4:0]  pc_b;
  logic        valid_a, done_a, fault_a, valid_b, done_b, fault_b;
  logic [15:0] cyc_a, ins_a, cyc_b, ins_b;
  int          n_chk, n_pass;

  assign instr_a = rom[pc_a];
  assign instr_b = rom[{5'd0, pc_b}];

  prog_sequencer dut_a (
    .Clk(clk), .Reset(rst), .Start(start), .Instruction(instr_a), .Jump(jump),
    .BranchEn(br), .Target(target), .MemStall(stall), .ProgCtr(pc_a),
    .InstrValid(valid_a), .Done(done_a), .Fault(fault_a), .CycleCount(cyc_a), .InstrCount(ins_a)
  );

  prog_sequencer #(.PC_W(5), .PROG_DEPTH(16)) dut_b (
    .Clk(clk), .Reset(rst), .Start(start), .Instruction(instr_b), .Jump(jump),
    .BranchEn(br), .Target(target[4:0]), .MemStall(stall), .ProgCtr(pc_b),
    .InstrValid(valid_b), .Done(done_b), .Fault(fault_b), .CycleCount(cyc_b), .InstrCount(ins_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a program either runs, or has finished (done, maybe with fault).
  typedef struct packed {
    bit run; bit done; bit fault; bit sp; int pc; int cyc; int ins;
  } mdl_t;
  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t m, int depth, int mask, bit st, logic [8:0] ins,
                                 bit j, bit b, int tgt, bit s);
    mdl_t n;
    int dest;
    n = m;
    n.sp = st;
    if (st) begin
      n = '0;
      n.sp = 1'b1;
      return n;
    end
    if (!m.run && !m.done && m.sp) n.run = 1'b1;
    if (m.run) begin
      n.cyc = (m.cyc < 65535) ? m.cyc + 1 : 65535;
      if (ins == HALT) begin
        n.run = 1'b0; n.done = 1'b1;
      end else if (!s) begin
        n.ins = (m.ins < 65535) ? m.ins + 1 : 65535;
        dest = (j && b) ? (tgt & mask) : m.pc + 1;
        if (dest >= depth) begin
          n.run = 1'b0; n.done = 1'b1; n.fault = 1'b1;
        end else n.pc = dest;
      end
    end
    return n;
  endfunction

  function automatic bit mvalid(mdl_t m, bit s);
    return m.run && !s && (rom[m.pc] != HALT);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ma = '0;
      mb = '0;
    end else begin
      ma = mstep(ma, 1024, 1023, start, rom[ma.pc], jump, br, int'(target), stall);
      mb = mstep(mb, 16, 31, start, rom[mb.pc], jump, br, int'(target), stall);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = NOP;
  endtask

  task automatic idle_inputs();
    start = 0; jump = 0; br = 0; stall = 0; target = '0;
  endtask

  task automatic launch();
    tick();
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    rst = 1'b0;
    #1;
    n_chk++; if ({pc_a, valid_a, done_a, fault_a, cyc_a, ins_a} !== '0)
      $display("FAIL reset_a got pc=%0d v=%b d=%b f=%b cyc=%0d ins=%0d want all 0", pc_a, valid_a, done_a, fault_a, cyc_a, ins_a);
    else n_pass++;
    n_chk++; if ({pc_b, valid_b, done_b, fault_b, cyc_b, ins_b} !== '0)
      $display("FAIL reset_b got pc=%0d d=%b f=%b want all 0", pc_b, done_b, fault_b);
    else n_pass++;
    repeat (4) tick();
    n_chk++; if (valid_a !== 1'b0 || cyc_a !== 16'd0)
      $display("FAIL stay_idle got v=%b cyc=%0d want v=0 cyc=0", valid_a, cyc_a);
    else n_pass++;
  endtask

  task automatic test_basic();
    int exp_pc [4] = '{0, 1, 2, 2};
    bit exp_v  [4] = '{1, 1, 0, 0};
    bit exp_d  [4] = '{0, 0, 0, 1};
    clear_rom();
    rom[2] = HALT;
    launch();
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (pc_a !== 10'(exp_pc[i]) || valid_a !== exp_v[i] || done_a !== exp_d[i])
        $display("FAIL basic[%0d] got pc=%0d v=%b d=%b want pc=%0d v=%b d=%b", i, pc_a, valid_a, done_a, exp_pc[i], exp_v[i], exp_d[i]);
      else n_pass++;
      if (i < 3) tick();
    end
    n_chk++; if (ins_a !== 16'd2 || cyc_a !== 16'd3 || fault_a !== 1'b0)
      $display("FAIL basic_counts got ins=%0d cyc=%0d f=%b want ins=2 cyc=3 f=0", ins_a, cyc_a, fault_a);
    else n_pass++;
  endtask

  task automatic test_jump();
    clear_rom();
    launch();
    repeat (5) tick();
    jump = 1; br = 1; target = 10'd40;
    tick();
    n_chk++; if (pc_a !== 10'd40 || pc_b !== 5'd8)
      $display("FAIL jump_taken got pc_a=%0d pc_b=%0d want 40 8", pc_a, pc_b);
    else n_pass++;
    idle_inputs();
    launch();
    repeat (5) tick();
    jump = 1; br = 0; target = 10'd40;
    #1;
    n_chk++; if (valid_a !== 1'b1)
      $display("FAIL jump_not_taken_valid got %b want 1", valid_a);
    else n_pass++;
    tick();
    n_chk++; if (pc_a !== 10'd6 || ins_a !== 16'd6)
      $display("FAIL jump_not_taken got pc=%0d ins=%0d want 6 6", pc_a, ins_a);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_stall();
    clear_rom();
    launch();
    repeat (7) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (pc_a !== 10'd7 || valid_a !== 1'b0)
        $display("FAIL stall[%0d] got pc=%0d v=%b want 7 0", i, pc_a, valid_a);
      else n_pass++;
      tick();
    end
    stall = 1'b0;
    tick();
    n_chk++; if (pc_a !== 10'd8 || cyc_a !== 16'd11 || ins_a !== 16'd8)
      $display("FAIL stall_after got pc=%0d cyc=%0d ins=%0d want 8 11 8", pc_a, cyc_a, ins_a);
    else n_pass++;
  endtask

  task automatic test_fault();
    clear_rom();
    launch();
    repeat (15) tick();
    n_chk++; if (pc_b !== 5'd15 || done_b !== 1'b0)
      $display("FAIL fault_pre got pc=%0d d=%b want 15 0", pc_b, done_b);
    else n_pass++;
    tick();
    n_chk++; if (done_b !== 1'b1 || fault_b !== 1'b1 || pc_b !== 5'd15 || ins_b !== 16'd16 || cyc_b !== 16'd16)
      $display("FAIL fault_end got d=%b f=%b pc=%0d ins=%0d cyc=%0d want 1 1 15 16 16", done_b, fault_b, pc_b, ins_b, cyc_b);
    else n_pass++;
    repeat (3) tick();
    n_chk++; if (cyc_b !== 16'd16 || done_a !== 1'b0 || pc_a !== 10'd19)
      $display("FAIL fault_frozen got cyc_b=%0d done_a=%b pc_a=%0d want 16 0 19", cyc_b, done_a, pc_a);
    else n_pass++;
    launch();
    repeat (3) tick();
    jump = 1; br = 1; target = 10'd20;
    tick();
    n_chk++; if (fault_b !== 1'b1 || done_b !== 1'b1 || pc_b !== 5'd3 || ins_b !== 16'd4)
      $display("FAIL fault_jump got f=%b d=%b pc=%0d ins=%0d want 1 1 3 4", fault_b, done_b, pc_b, ins_b);
    else n_pass++;
    n_chk++; if (pc_a !== 10'd20 || fault_a !== 1'b0)
      $display("FAIL fault_jump_a got pc=%0d f=%b want 20 0", pc_a, fault_a);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_restart();
    clear_rom();
    launch();
    repeat (9) tick();
    start = 1'b1;
    tick();
    n_chk++; if (pc_a !== 10'd0 || cyc_a !== 16'd0 || ins_a !== 16'd0 || done_a !== 1'b0 || valid_a !== 1'b0)
      $display("FAIL restart_idle got pc=%0d cyc=%0d ins=%0d d=%b v=%b want 0 0 0 0 0", pc_a, cyc_a, ins_a, done_a, valid_a);
    else n_pass++;
    start = 1'b0;
    tick();
    n_chk++; if (pc_a !== 10'd0 || valid_a !== 1'b1)
      $display("FAIL restart_run got pc=%0d v=%b want 0 1", pc_a, valid_a);
    else n_pass++;
    tick();
    n_chk++; if (pc_a !== 10'd1 || cyc_a !== 16'd1)
      $display("FAIL restart_step got pc=%0d cyc=%0d want 1 1", pc_a, cyc_a);
    else n_pass++;
  endtask

  task automatic test_reset_priority();
    clear_rom();
    launch();
    repeat (4) tick();
    rst = 1'b1; start = 1'b1;
    tick();
    n_chk++; if ({pc_a, valid_a, done_a, fault_a, cyc_a, ins_a} !== '0)
      $display("FAIL rst_start got pc=%0d v=%b cyc=%0d ins=%0d want all 0", pc_a, valid_a, cyc_a, ins_a);
    else n_pass++;
    rst = 1'b0; start = 1'b0;
    repeat (3) tick();
    n_chk++; if (valid_a !== 1'b0 || pc_a !== 10'd0 || cyc_a !== 16'd0)
      $display("FAIL rst_no_run got v=%b pc=%0d cyc=%0d want 0 0 0", valid_a, pc_a, cyc_a);
    else n_pass++;
    rom[1] = HALT;
    launch();
    repeat (2) tick();
    n_chk++; if (done_a !== 1'b1 || fault_a !== 1'b0 || pc_a !== 10'd1)
      $display("FAIL halt_done got d=%b f=%b pc=%0d want 1 0 1", done_a, fault_a, pc_a);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if (done_a !== 1'b0 || pc_a !== 10'd0 || ins_a !== 16'd0)
      $display("FAIL halt_reset got d=%b pc=%0d ins=%0d want 0 0 0", done_a, pc_a, ins_a);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [44:0] exp_a, got_a;
    logic [39:0] exp_b, got_b;
    for (int ep = 0; ep < 8; ep++) begin
      for (int i = 0; i < 1024; i++)
        rom[i] = ($urandom_range(0, 29) == 0) ? HALT : 9'($urandom_range(0, 510));
      idle_inputs();
      launch();
      for (int c = 0; c < 80; c++) begin
        start  = ($urandom_range(0, 59) == 0);
        stall  = ($urandom_range(0, 3) == 0);
        jump   = ($urandom_range(0, 2) == 0);
        br     = 1'($urandom_range(0, 1));
        target = ($urandom_range(0, 2) == 0) ? 10'($urandom) : 10'($urandom_range(0, 40));
        #1;
        exp_a = {10'(ma.pc), mvalid(ma, stall), ma.done, ma.fault, 16'(ma.cyc), 16'(ma.ins)};
        got_a = {pc_a, valid_a, done_a, fault_a, cyc_a, ins_a};
        exp_b = {5'(mb.pc), mvalid(mb, stall), mb.done, mb.fault, 16'(mb.cyc), 16'(mb.ins)};
        got_b = {pc_b, valid_b, done_b, fault_b, cyc_b, ins_b};
        n_chk++; if (got_a !== exp_a)
          $display("FAIL rand_a ep%0d c%0d got %h want %h", ep, c, got_a, exp_a);
        else n_pass++;
        n_chk++; if (got_b !== exp_b)
          $display("FAIL rand_b ep%0d c%0d got %h want %h", ep, c, got_b, exp_b);
        else n_pass++;
        tick();
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    clear_rom();
    launch();
    jump = 1; br = 1; target = 10'd0;
    repeat (65540) tick();
    n_chk++; if (cyc_a !== 16'hFFFF || ins_a !== 16'hFFFF || pc_a !== 10'd0 || done_a !== 1'b0)
      $display("FAIL sat_a got cyc=%h ins=%h pc=%0d d=%b want ffff ffff 0 0", cyc_a, ins_a, pc_a, done_a);
    else n_pass++;
    n_chk++; if (cyc_b !== 16'hFFFF || ins_b !== 16'hFFFF)
      $display("FAIL sat_b got cyc=%h ins=%h want ffff ffff", cyc_b, ins_b);
    else n_pass++;
    idle_inputs();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    clear_rom();
    test_reset();
    test_basic();
    test_jump();
    test_stall();
    test_fault();
    test_restart();
    test_reset_priority();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
